// File: rtl/seven_seg_pkg.sv
// Shared constants and elaboration helpers for the seven-segment scanner.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam logic [6:0] BLANK_SEG = 7'h7F;

    // Ceiling log2, never less than 1 so single-entry selects still get a bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int num_digits(input int data_w);
        return data_w / 4;
    endfunction

endpackage

// File: rtl/binary_to_7Seg.sv
// Hex nibble to active-low seven-segment pattern, {g,f,e,d,c,b,a}.
module binary_to_7Seg (
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (bin)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed hex display of one selectable register, with a per-slot
// deadtime cycle, optional leading-zero blanking and a freeze control.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_REGS    = 16,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REGS*DATA_W-1:0]           regs,
    input  logic [clog2(NUM_REGS)-1:0]           sel,
    input  logic                                 freeze,
    input  logic                                 blank_lz,
    output logic [6:0]                           seg,
    output logic [num_digits(DATA_W)-1:0]        an
);

    localparam int NUM_DIGITS = num_digits(DATA_W);
    localparam int SEL_W      = clog2(NUM_REGS);
    localparam int IDX_W      = clog2(NUM_DIGITS);
    localparam int CNT_W      = clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic              tick;
    logic              frame_start;
    logic [DATA_W-1:0] sel_val;
    logic [3:0]        nibble;
    logic              upper_zero;
    logic              deadtime;
    logic              blank;
    logic [6:0]        dec_seg;

    // Out-of-range selects match no entry and therefore load zero.
    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_val = regs[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        tick        = (cnt_q == CNT_MAX);
        frame_start = tick && (idx_q == IDX_MAX);
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        idx_d       = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        sel_d    = sel;
        shadow_d = shadow_q;
        if (!freeze && (frame_start || (sel != sel_q))) begin
            shadow_d = sel_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            sel_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
        end
    end

    // Output decode depends only on registered state, plus blank_lz.
    always_comb begin
        nibble     = '0;
        upper_zero = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nibble     = shadow_q[k*4 +: 4];
                upper_zero = ((shadow_q >> (k*4)) == '0);
            end
        end
    end

    binary_to_7Seg u_dec (
        .bin (nibble),
        .seg (dec_seg)
    );

    always_comb begin
        deadtime = (cnt_q == '0);
        blank    = blank_lz && (idx_q != '0) && upper_zero;
        an       = '1;
        if (!deadtime) begin
            an = ~(NUM_DIGITS'(1) << idx_q);
        end
        seg = (deadtime || blank) ? BLANK_SEG : dec_seg;
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: a cycle-count reference model pushes expected an/seg,
// a negedge monitor pops and compares against the scanner outputs.
module tb_seven_seg_scanner;

    localparam int NR    = 16;
    localparam int DW    = 16;
    localparam int RD    = 4;
    localparam int ND    = 4;
    localparam int FRAME = RD * ND;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NR*DW-1:0] regs = '0;
    logic [3:0]       sel = '0;
    logic             freeze = 1'b0;
    logic             blank_lz = 1'b0;
    logic [6:0]       seg;
    logic [3:0]       an;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;
    exp_t exp_q[$];

    // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F.
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state: cycles since reset, displayed value, previous select.
    int unsigned t = 0;
    logic [15:0] shadow_m = '0;
    int          sel_prev = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(.NUM_REGS(NR), .DATA_W(DW), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst      (rst),
        .regs     (regs),
        .sel      (sel),
        .freeze   (freeze),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an)
    );

    function automatic exp_t model_out();
        exp_t e;
        int cnt, idx;
        logic [15:0] upper;
        cnt = int'(t % RD);
        idx = int'((t / RD) % ND);
        e.an  = 4'hF;
        e.seg = 7'h7F;
        if (!rst && cnt != 0) begin
            e.an  = ~(4'b0001 << idx);
            upper = shadow_m >> (4 * idx);
            if (blank_lz && idx > 0 && upper == 16'h0) e.seg = 7'h7F;
            else e.seg = seg_tbl[upper[3:0]];
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t        = 0;
            shadow_m = '0;
            sel_prev = 0;
            exp_q.delete();
        end else begin
            if (!freeze && (((t + 1) % FRAME) == 0 || int'(sel) != sel_prev))
                shadow_m = regs[int'(sel)*DW +: DW];
            sel_prev = int'(sel);
            t = t + 1;
        end
        exp_q.push_back(model_out());
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (an !== e.an) begin
                failures++;
                $display("FAIL an t=%0d: got %h, expected %h", t, an, e.an);
            end
            checks++;
            if (seg !== e.seg) begin
                failures++;
                $display("FAIL seg t=%0d: got %h, expected %h", t, seg, e.seg);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_reg(input int i, input logic [15:0] v);
        regs[i*DW +: DW] = v;
    endtask

    // Asserts reset in the middle of a clock-high phase and checks the blanked outputs at once.
    task automatic async_reset_check(input string name);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            failures++;
            $display("FAIL %s: an=%h seg=%h, expected an=f seg=7f", name, an, seg);
        end
    endtask

    initial begin
        logic [15:0] v;
        int z;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            failures++;
            $display("FAIL reset_async: an=%h seg=%h, expected an=f seg=7f", an, seg);
        end
        step(3);
        rst = 1'b0;
        step(FRAME);

        set_reg(3, 16'h1234);
        step(2);
        sel = 4'd3;
        step(3 * FRAME);

        blank_lz = 1'b1;
        set_reg(3, 16'h0050);
        step(2 * FRAME);
        set_reg(3, 16'h0000);
        step(2 * FRAME);
        set_reg(3, 16'h1234);
        step(FRAME);

        freeze = 1'b1;
        set_reg(3, 16'hBEEF);
        set_reg(4, 16'hA5C3);
        step(3);
        sel = 4'd4;
        step(1);
        sel = 4'd3;
        step(3 * FRAME);
        freeze = 1'b0;
        step(2 * FRAME);

        async_reset_check("reset_pre");
        step(2);
        rst = 1'b0;
        step(9);
        async_reset_check("reset_midframe");
        step(2);
        rst = 1'b0;
        step(2 * FRAME);

        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(3, 0) == 0) begin
                v = 16'($urandom);
                z = $urandom_range(4, 0);
                v = v >> (4 * z);
                set_reg($urandom_range(NR - 1, 0), v);
            end
            if ($urandom_range(19, 0) == 0) sel = 4'($urandom_range(NR - 1, 0));
            if ($urandom_range(39, 0) == 0) freeze = ~freeze;
            if ($urandom_range(29, 0) == 0) blank_lz = ~blank_lz;
            if (rst) rst = 1'b0;
            else if ($urandom_range(299, 0) == 0) rst = 1'b1;
            step(1);
        end
        rst = 1'b0;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
